// File: rtl/debouncer_bank.sv
// ---------------------------------------------------------------------------
// debouncer_bank
//   Multi-channel push-button debouncer for the vending machine front panel.
//   Each channel runs a 2-FF synchroniser followed by a stability counter;
//   a new level is accepted only after it has persisted STABLE_CYCLES
//   consecutive synchronised samples. Accepted level changes are reported
//   as registered one-cycle rise/fall pulses aligned with the first cycle
//   of the new level.
//
//   Optional feature (macro DEBOUNCER_LONGPRESS_EN): per-channel long-press
//   detector that pulses long_press once after out has been high for
//   LONG_CYCLES cycles. With the macro undefined, long_press is tied low
//   and no long-press logic is built; the port list is identical.
//
// Parameters
//   CHANNELS       number of independent channels (>=1)
//   STABLE_CYCLES  samples a new level must persist before acceptance (>=2)
//   INVERT_IN      1: raw inputs are active-low, inverted before the sync FFs
//   LONG_CYCLES    accepted-high cycles before long_press fires (>=1)
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   in          raw button inputs, asynchronous to clk
//   out         debounced level
//   rise        one-cycle pulse when out goes 0->1
//   fall        one-cycle pulse when out goes 1->0
//   long_press  one-cycle pulse when out has been high LONG_CYCLES cycles
// ---------------------------------------------------------------------------
module debouncer_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int INVERT_IN     = 0,
  parameter int LONG_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] INV_MASK = (INVERT_IN != 0) ? '1 : '0;

  // Stability FSM state is the accepted level itself.
  localparam logic [0:0] IDLE_LO = 1'b0;
  localparam logic [0:0] IDLE_HI = 1'b1;

  // Elaboration-time parameter sanity checks.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("debouncer_bank: CHANNELS must be >= 1");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debouncer_bank: STABLE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("debouncer_bank: LONG_CYCLES must be >= 1");
  end

  // -------------------------------------------------------------------------
  // Two-flop synchroniser, polarity fixed before the first flop.
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in ^ INV_MASK;
      s2 <= s1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel stability counter and edge pulses.
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt    <= '0;
        lvl    <= IDLE_LO;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (s2[c] == lvl) begin
          // Any return to the accepted level restarts qualification.
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end else begin
          lvl    <= s2[c];
          cnt    <= '0;
          rise_q <= (lvl == IDLE_LO);
          fall_q <= (lvl == IDLE_HI);
        end
      end
    end

    assign out[c]  = lvl;
    assign rise[c] = rise_q;
    assign fall[c] = fall_q;

`ifdef DEBOUNCER_LONGPRESS_EN
    localparam int LP_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_CYCLES);

    logic [LP_W-1:0] lp_cnt;
    logic            lp_q;

    // lp_cnt saturates at LONG_CYCLES so the pulse fires once per press.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lp_cnt <= '0;
        lp_q   <= 1'b0;
      end else begin
        lp_q <= 1'b0;
        if (lvl == IDLE_LO) begin
          lp_cnt <= '0;
        end else if (lp_cnt != LP_MAX) begin
          lp_cnt <= lp_cnt + 1'b1;
          lp_q   <= (lp_cnt == LP_MAX - 1'b1);
        end
      end
    end

    assign long_press[c] = lp_q;
`else
    assign long_press[c] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// ---------------------------------------------------------------------------
// tb_debouncer_bank
//   Directed plus randomised stimulus for debouncer_bank (4 channels,
//   STABLE_CYCLES=4, LONG_CYCLES=6, INVERT_IN=0). The reference model keeps
//   the history of raw samples and accepts a new level when the last
//   STABLE_CYCLES synchronised samples (inputs delayed two edges) all differ
//   from the current level.
// ---------------------------------------------------------------------------
module tb_debouncer_bank;

  localparam int N   = 4;
  localparam int S   = 4;
  localparam int L   = 6;
  localparam int INV = 0;
  localparam logic [N-1:0] INV_MASK = (INV != 0) ? 4'hF : 4'h0;

  logic         clk;
  logic         reset;
  logic [N-1:0] in;
  logic [N-1:0] out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] long_press;

  debouncer_bank #(
    .CHANNELS      (N),
    .STABLE_CYCLES (S),
    .INVERT_IN     (INV),
    .LONG_CYCLES   (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .out        (out),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] hist[$];
  logic [N-1:0] out_m;
  logic [N-1:0] rise_m;
  logic [N-1:0] fall_m;
  logic [N-1:0] lp_m;
  int           lp_cnt_m[N];

  int total;
  int passed;
  int lp_pulses;

  task automatic check(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    hist.delete();
    // Sync flops hold 0 out of reset: two zero samples precede real input.
    hist.push_back('0);
    hist.push_back('0);
    out_m  = '0;
    rise_m = '0;
    fall_m = '0;
    lp_m   = '0;
    for (int c = 0; c < N; c++) lp_cnt_m[c] = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] v);
    logic [N-1:0] nout;
    int t;
    int idx;
    bit ok;
    hist.push_back(v ^ INV_MASK);
    t      = hist.size() - 1;
    nout   = out_m;
    rise_m = '0;
    fall_m = '0;
    lp_m   = '0;
    for (int c = 0; c < N; c++) begin
      if (out_m[c]) begin
        if (lp_cnt_m[c] < L) begin
          lp_cnt_m[c]++;
          if (lp_cnt_m[c] == L) lp_m[c] = 1'b1;
        end
      end else begin
        lp_cnt_m[c] = 0;
      end
      ok = 1'b1;
      for (int k = 0; k < S; k++) begin
        idx = t - 2 - k;
        if (idx < 0) ok = 1'b0;
        else if (hist[idx][c] == out_m[c]) ok = 1'b0;
      end
      if (ok) begin
        nout[c]   = ~out_m[c];
        rise_m[c] = ~out_m[c];
        fall_m[c] = out_m[c];
      end
    end
    out_m = nout;
  endtask

  task automatic check_all();
    logic [N-1:0] lp_exp;
`ifdef DEBOUNCER_LONGPRESS_EN
    lp_exp = lp_m;
`else
    lp_exp = '0;
`endif
    check("out", out, out_m);
    check("rise", rise, rise_m);
    check("fall", fall, fall_m);
    check("long_press", long_press, lp_exp);
    check("rise_fall_excl", rise & fall, '0);
    if (long_press[0]) lp_pulses++;
  endtask

  task automatic step(input logic [N-1:0] v);
    in = v;
    @(posedge clk);
    if (reset) model_edge(v);
    #1;
    check_all();
  endtask

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] lp_once_exp;
    total     = 0;
    passed    = 0;
    lp_pulses = 0;

    // Reset held with all buttons pressed
    reset = 1'b0;
    in    = 4'hF;
    model_reset();
    step(4'hF);
    step(4'hF);
    check("reset_out", out, 4'h0);

    // Release: out=F after the sixth edge, rise=F for that cycle only
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(4'hF);
      if (i == 5) check("rel_lat5_out", out, 4'h0);
      if (i == 6) begin
        check("rel_lat6_out", out, 4'hF);
        check("rel_lat6_rise", rise, 4'hF);
      end
      if (i == 7) check("rel_lat7_rise", rise, 4'h0);
    end

    // All released
    for (int i = 1; i <= 8; i++) step(4'h0);
    check("all_low", out, 4'h0);

    // Clean press ch0
    for (int i = 1; i <= 10; i++) begin
      step(4'h1);
      if (i == 6) begin
        check("press_out", out, 4'h1);
        check("press_rise", rise, 4'h1);
      end
    end

    // Bounce ch1 (3 high, 1 low, 3 high, low) while ch0 stays held
    lp_pulses = 0;
    for (int i = 0; i < 11; i++) begin
      cur = 4'h1;
      if ((i < 3) || (i >= 4 && i < 7)) cur[1] = 1'b1;
      step(cur);
      check("bounce_out1", {3'b000, out[1]}, 4'h0);
      check("bounce_rise1", {3'b000, rise[1]}, 4'h0);
    end
    for (int i = 0; i < 10; i++) step(4'h1);
`ifdef DEBOUNCER_LONGPRESS_EN
    lp_once_exp = 4'h1;
`else
    lp_once_exp = 4'h0;
`endif
    // Long press ch0 is first seen 12 edges into the hold (inside bounce phase)
    check("lp_once", 4'(lp_pulses), lp_once_exp);

    // Release ch0
    for (int i = 1; i <= 8; i++) begin
      step(4'h0);
      if (i == 6) begin
        check("release_out", out, 4'h0);
        check("release_fall", fall, 4'h1);
      end
    end

    // Concurrent: ch3 goes high first, then ch2 rises while ch3 falls
    for (int i = 1; i <= 8; i++) step(4'h8);
    check("conc_pre", out, 4'h8);
    for (int i = 1; i <= 8; i++) begin
      step(4'h4);
      if (i == 6) begin
        check("conc_rise", rise, 4'h4);
        check("conc_fall", fall, 4'h8);
      end
    end

    // Reset mid-count on ch0 (cnt=2 after four edges)
    for (int i = 1; i <= 4; i++) step(4'h5);
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_out", out, 4'h0);
    check("midrst_rise", rise, 4'h0);
    step(4'h5);
    step(4'h5);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(4'h5);
      if (i == 5) check("midrst_lat5", out, 4'h0);
      if (i == 6) begin
        check("midrst_lat6_out", out, 4'h5);
        check("midrst_lat6_rise", rise, 4'h5);
      end
    end

    // Randomised slow-toggling inputs
    cur = 4'h5;
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 4) == 0) cur[c] = ~cur[c];
      step(cur);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
